rsa_crypt: RTL

- Modular-exponentiation engine that consumes the key material produced by key generation: computes result = base^exp mod n.
- Used as the encrypt side (exp = e, zero-extended) and as the decrypt side (exp = d). It is the block whose timing the side-channel study measures.
- Right-to-left square-and-multiply built on one serial interleaved modular multiplier.
- Default build is deliberately data-dependent in latency.

---
 rtl/rsa_pkg.sv | 16 +
 rtl/mod_mult.sv | 81 ++++++++
 rtl/rsa_crypt.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/rsa_pkg.sv
// Shared definitions for the rsa_crypt modular-exponentiation engine.
// The constant-time build option (macro RSA_CONST_TIME_EN) is consumed by rsa_crypt.sv.
package rsa_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_CHECK = 3'd1;
    localparam logic [2:0] ST_MUL   = 3'd2;
    localparam logic [2:0] ST_SQR   = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    // Cycles spent in one MUL or SQR phase: launch, 2*WIDTH iterations, capture.
    function automatic int PHASE_LEN(input int width);
        return 2 * width + 2;
    endfunction

endpackage

// File: rtl/mod_mult.sv
// Serial interleaved modular multiplier: out = a*b mod n, scanning b MSB-first.
// Operands are latched on start; finish pulses 2*WIDTH+1 cycles after start.
module mod_mult
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] a,
    input  logic [2*WIDTH-1:0] b,
    input  logic [2*WIDTH-1:0] n,
    output logic [2*WIDTH-1:0] out,
    output logic               finish
);

    localparam int OW    = 2 * WIDTH;
    localparam int IW    = 2 * WIDTH + 2;
    localparam int ITERS = PHASE_LEN(WIDTH) - 2;
    localparam int CW    = $clog2(ITERS + 1);

    logic [OW-1:0] r_q, r_d, a_q, b_q, n_q;
    logic [CW-1:0] cnt_q;
    logic          finish_q;
    logic [IW-1:0] dbl_s, red1_s, add_s, n_ext_s, a_ext_s;

    // One interleaved step; r and a are both below n, so IW bits never overflow.
    always_comb begin
        n_ext_s = {2'b00, n_q};
        a_ext_s = {2'b00, a_q};
        dbl_s   = {1'b0, r_q, 1'b0};
        if (dbl_s >= n_ext_s) begin
            red1_s = dbl_s - n_ext_s;
        end else begin
            red1_s = dbl_s;
        end
        if (b_q[OW-1]) begin
            add_s = red1_s + a_ext_s;
        end else begin
            add_s = red1_s;
        end
        if (add_s >= n_ext_s) begin
            r_d = OW'(add_s - n_ext_s);
        end else begin
            r_d = OW'(add_s);
        end
    end

    // Operand latch, iteration counter and finish pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            n_q      <= '0;
            cnt_q    <= '0;
            finish_q <= 1'b0;
        end else begin
            finish_q <= 1'b0;
            if (start) begin
                r_q   <= '0;
                a_q   <= a;
                b_q   <= b;
                n_q   <= n;
                cnt_q <= CW'(ITERS);
            end else if (cnt_q != '0) begin
                r_q   <= r_d;
                b_q   <= {b_q[OW-2:0], 1'b0};
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    finish_q <= 1'b1;
                end
            end
        end
    end

    assign out    = r_q;
    assign finish = finish_q;

endmodule

// File: rtl/rsa_crypt.sv
// Right-to-left square-and-multiply engine: result = base^exp mod n.
// Define RSA_CONST_TIME_EN for operand-independent latency (n<2 still short-circuits).
module rsa_crypt
    import rsa_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [2*WIDTH-1:0] base,
    input  logic [2*WIDTH-1:0] exp,
    input  logic [2*WIDTH-1:0] n,
    output logic [2*WIDTH-1:0] result,
    output logic               busy,
    output logic               finish
);

    localparam int            OW  = 2 * WIDTH;
    localparam logic [OW-1:0] ONE = OW'(1);

    logic [2:0]    state_q, state_d;
    logic [OW-1:0] acc_q, acc_d, sq_q, sq_d, e_sh_q, e_sh_d, n_q, n_d;
    logic [OW-1:0] result_q, result_d;
    logic          busy_q, busy_d, finish_q, finish_d;
    logic          pend_q, pend_d;
    logic          mm_start_s, mm_finish_s;
    logic [OW-1:0] mm_a_s, mm_out_s;
    logic          last_s, take_mul_s, write_mul_s;

`ifdef RSA_CONST_TIME_EN
    localparam int CW = $clog2(OW + 1);
    logic [CW-1:0] bit_cnt_q;

    // Counts completed exponent bits so every operand walks the full width.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt_q <= '0;
        end else if (state_q == ST_IDLE && start) begin
            bit_cnt_q <= '0;
        end else if (state_q == ST_SQR && !pend_q && mm_finish_s) begin
            bit_cnt_q <= bit_cnt_q + CW'(1);
        end
    end

    // Multiply on every bit; the product is kept only for set bits.
    always_comb begin
        last_s      = (bit_cnt_q == CW'(OW));
        take_mul_s  = 1'b1;
        write_mul_s = e_sh_q[0];
    end
`else
    // Stop at the top set bit and skip multiplies for clear bits.
    always_comb begin
        last_s      = (e_sh_q == '0);
        take_mul_s  = e_sh_q[0];
        write_mul_s = 1'b1;
    end
`endif

    // Sequencer; CHECK launches the first multiply of each bit, SQR relaunches after MUL.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        sq_d       = sq_q;
        e_sh_d     = e_sh_q;
        n_d        = n_q;
        result_d   = result_q;
        busy_d     = busy_q;
        finish_d   = 1'b0;
        pend_d     = pend_q;
        mm_start_s = 1'b0;
        mm_a_s     = sq_q;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    acc_d   = ONE;
                    sq_d    = base;
                    e_sh_d  = exp;
                    n_d     = n;
                    busy_d  = 1'b1;
                    pend_d  = 1'b0;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CHECK: begin
                if (n_q[OW-1:1] == '0) begin
                    acc_d   = '0;
                    state_d = ST_DONE;
                end else if (last_s) begin
                    state_d = ST_DONE;
                end else if (take_mul_s) begin
                    mm_start_s = 1'b1;
                    mm_a_s     = acc_q;
                    state_d    = ST_MUL;
                end else begin
                    mm_start_s = 1'b1;
                    state_d    = ST_SQR;
                end
            end
            ST_MUL: begin
                if (mm_finish_s) begin
                    if (write_mul_s) begin
                        acc_d = mm_out_s;
                    end else begin
                        acc_d = acc_q;
                    end
                    pend_d  = 1'b1;
                    state_d = ST_SQR;
                end else begin
                    state_d = ST_MUL;
                end
            end
            ST_SQR: begin
                if (pend_q) begin
                    mm_start_s = 1'b1;
                    pend_d     = 1'b0;
                end else if (mm_finish_s) begin
                    sq_d    = mm_out_s;
                    e_sh_d  = e_sh_q >> 1;
                    state_d = ST_CHECK;
                end else begin
                    state_d = ST_SQR;
                end
            end
            ST_DONE: begin
                result_d = acc_q;
                finish_d = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            sq_q     <= '0;
            e_sh_q   <= '0;
            n_q      <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            finish_q <= 1'b0;
            pend_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            sq_q     <= sq_d;
            e_sh_q   <= e_sh_d;
            n_q      <= n_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            finish_q <= finish_d;
            pend_q   <= pend_d;
        end
    end

    mod_mult #(.WIDTH(WIDTH)) u_mult (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (mm_start_s),
        .a      (mm_a_s),
        .b      (sq_q),
        .n      (n_q),
        .out    (mm_out_s),
        .finish (mm_finish_s)
    );

    assign result = result_q;
    assign busy   = busy_q;
    assign finish = finish_q;

endmodule
